// File: rtl/seq_multiplier_32bit_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Holds the FSM state encoding and the default operand width.
package seq_multiplier_32bit_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_multiplier_32bit_if.sv
// Start/done handshake and operand/product bus of the multiplier.
// master = ALU control side, slave = multiplier side.
interface seq_multiplier_32bit_if;
  import seq_multiplier_32bit_pkg::*;

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   product_lo;
  logic [WIDTH-1:0]   product_hi;

  modport master (
    output start, a, b,
    input  busy, done, product,
    input  product_lo, product_hi
  );

  modport slave (
    input  start, a, b,
    output busy, done, product,
    output product_lo, product_hi
  );

endinterface

// File: rtl/seq_multiplier_32bit_datapath.sv
// Multiplicand register, carry-extended accumulator and product register.
// One conditional add plus right shift per enabled cycle.
module seq_mult_datapath
  import seq_multiplier_32bit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               add_en,
  input  logic               shift_en,
  input  logic               prod_en,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               acc_lsb,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   step;

  // sum carries one extra bit so the top add never loses its carry
  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + {1'b0, mcand_q};
    step    = add_en ? {sum, acc_q[WIDTH-1:0]}
                     : {1'b0, acc_q};
    if (load) begin
      mcand_d = a;
      acc_d   = {{WIDTH{1'b0}}, b};
    end else if (shift_en) begin
      acc_d = (2*WIDTH)'(step >> 1);
    end
    if (prod_en) prod_d = acc_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign acc_lsb = acc_q[0];
  assign product = prod_q;

endmodule

// File: rtl/seq_multiplier_32bit.sv
// Sequential unsigned multiplier: FSM, step counter and handshake.
// Product register is loaded on the final step so it is valid with done.
module seq_multiplier_32bit
  import seq_multiplier_32bit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  seq_multiplier_32bit_if.slave bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               load;
  logic               add_en;
  logic               shift_en;
  logic               prod_en;
  logic               acc_lsb;
  logic [2*WIDTH-1:0] product;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    add_en   = 1'b0;
    shift_en = 1'b0;
    prod_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        shift_en = 1'b1;
        add_en   = acc_lsb;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          prod_en = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      // unused encoding recovers to idle
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_CALC) || (state_d == ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  seq_mult_datapath u_dp (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .add_en   (add_en),
    .shift_en (shift_en),
    .prod_en  (prod_en),
    .a        (bus.a),
    .b        (bus.b),
    .acc_lsb  (acc_lsb),
    .product  (product)
  );

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.product    = product;
  assign bus.product_lo = product[WIDTH-1:0];
  assign bus.product_hi = product[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Bench for seq_multiplier_32bit: cycle model + directed vectors.
// Model: accepted start -> busy for W+1 cycles, done and a*b on the last.
module tb_seq_multiplier_32bit;
  import seq_multiplier_32bit_pkg::*;

  localparam int LAT = WIDTH + 1;
  localparam int LIM = 200;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;
  bit   cmp_en = 1'b0;

  int          m_cyc = 0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_prod = '0;

  seq_multiplier_32bit_if mif ();

  seq_multiplier_32bit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Behavioural model of the handshake and arithmetic
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cyc  = 0;
      m_pend = '0;
      m_prod = '0;
    end else if (m_cyc == 0) begin
      if (mif.start) begin
        m_cyc  = 1;
        m_pend = 64'(mif.a) * 64'(mif.b);
      end
    end else if (m_cyc == LAT) begin
      m_cyc = 0;
    end else begin
      m_cyc++;
      if (m_cyc == LAT) m_prod = m_pend;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 64'(mif.busy), 64'(m_cyc != 0));
      chk("done", 64'(mif.done), 64'(m_cyc == LAT));
      chk("product", mif.product, m_prod);
      chk("product_lo", 64'(mif.product_lo),
          64'(m_prod[31:0]));
      chk("product_hi", 64'(mif.product_hi),
          64'(m_prod[63:32]));
    end
    if (mif.done) n_done++;
  end

  task automatic wait_op(input bit drop,
                         input int chg_at,
                         output int lat,
                         output int bcnt);
    lat  = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mif.busy) bcnt++;
      if (drop && lat == 1) mif.start = 1'b0;
      if (chg_at != 0 && lat == chg_at) begin
        mif.a = 32'd9;
        mif.b = 32'd9;
      end
    end while (!mif.done && lat < LIM);
    if (!mif.done) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: no done after %0d cycles", lat);
    end
  endtask

  task automatic mul(input string nm,
                     input logic [31:0] av,
                     input logic [31:0] bv,
                     input logic [63:0] exp);
    int lat;
    int bc;
    mif.start = 1'b1;
    mif.a     = av;
    mif.b     = bv;
    wait_op(1'b1, 0, lat, bc);
    chk({nm, "_lat"}, 64'(lat), 64'(33));
    chk({nm, "_busycyc"}, 64'(bc), 64'(33));
    chk({nm, "_prod"}, mif.product, exp);
    chk({nm, "_hi"}, 64'(mif.product_hi), 64'(exp[63:32]));
    @(negedge clk);
    chk({nm, "_busy_after"}, 64'(mif.busy), 64'(0));
    chk({nm, "_held"}, mif.product, exp);
  endtask

  initial begin
    int lat;
    int bc;
    mif.start = 1'b0;
    mif.a     = '0;
    mif.b     = '0;
    #1 reset = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(mif.busy), 64'(0));
    chk("rst_done", 64'(mif.done), 64'(0));
    chk("rst_prod", mif.product, 64'(0));
    reset = 1'b0;

    mul("basic", 32'd7, 32'd6, 64'd42);
    mul("max", 32'hFFFFFFFF, 32'hFFFFFFFF,
        64'hFFFFFFFE00000001);
    mul("zero", 32'd0, 32'h12345678, 64'd0);
    mul("ident", 32'h12345678, 32'd1, 64'h12345678);

    // start held high; operands change mid-run
    mif.start = 1'b1;
    mif.a     = 32'd3;
    mif.b     = 32'd5;
    wait_op(1'b0, 10, lat, bc);
    chk("bsy1_lat", 64'(lat), 64'(33));
    chk("bsy1_prod", mif.product, 64'd15);
    @(negedge clk);
    chk("bsy_gap_busy", 64'(mif.busy), 64'(0));
    chk("bsy_gap_done", 64'(mif.done), 64'(0));
    wait_op(1'b1, 0, lat, bc);
    chk("bsy2_lat", 64'(lat), 64'(33));
    chk("bsy2_prod", mif.product, 64'd81);
    @(negedge clk);

    // reset in the middle of an operation
    mif.start = 1'b1;
    mif.a     = 32'd100;
    mif.b     = 32'd100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mif.start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(mif.busy), 64'(0));
    chk("mid_rst_done", 64'(mif.done), 64'(0));
    chk("mid_rst_prod", mif.product, 64'(0));
    @(negedge clk);
    reset = 1'b0;
    mul("post_rst", 32'd4, 32'd4, 64'd16);

    // hold: operands wiggle with start low
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mif.a = $urandom;
      mif.b = $urandom;
      chk("hold_prod", mif.product, 64'd16);
      chk("hold_busy", 64'(mif.busy), 64'(0));
    end

    chk("done_count", 64'(n_done), 64'(7));
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
